// File: rtl/riscv_regfile_debug_port_pkg.sv
// Shared encodings for the register-file debug port: command opcodes and FSM states.
package riscv_dbg_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_RSVD  = 2'b11
  } dbg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CAPT   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } dbg_state_e;

endpackage

// File: rtl/riscv_regfile_debug_port_if.sv
// Command/response channels plus the register-file port driven by the debug initiator.
interface riscv_regfile_debug_port_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [XLEN-1:0]   cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_last;
  logic              rsp_err;
  logic              rf_regWrite;
  logic [ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]   rf_data;
  logic [ADDR_W-1:0] rf_rs1;
  logic [XLEN-1:0]   rf_rdata1;
  logic              dbg_active;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, rf_rdata1,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err,
    input  rf_regWrite, rf_rd, rf_data, rf_rs1, dbg_active
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready, rf_rdata1,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err,
    output rf_regWrite, rf_rd, rf_data, rf_rs1, dbg_active
  );
endinterface

// File: rtl/riscv_regfile_debug_port.sv
// Debug initiator for the RV32I register file: serialises READ/WRITE/DUMP commands onto the
// register-file ports and streams results back over a valid/ready response channel.
module riscv_regfile_debug_port
  import riscv_dbg_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ADDR_W        = 5,
  parameter int NUM_REGS      = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  riscv_regfile_debug_port_if.slave bus
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  dbg_state_e        r_state;
  dbg_state_e        w_state_next;
  logic [CNT_W-1:0]  r_settle_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_dump;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic [XLEN-1:0]   r_rsp_data;
  logic              r_rsp_last;
  logic              r_rsp_err;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_rd;
  logic [XLEN-1:0]   r_rf_data;
  logic [ADDR_W-1:0] r_rf_rs1;

  logic w_cmd_ready;
  logic w_accept;
  logic w_settle_done;
  logic w_rsp_fire;
  logic w_idx_last;

  assign w_cmd_ready   = rst_n && (r_state == ST_IDLE);
  assign w_accept      = bus.cmd_valid && w_cmd_ready;
  assign w_settle_done = (r_settle_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_rsp_fire    = r_rsp_valid && bus.rsp_ready;
  assign w_idx_last    = (r_idx == ADDR_W'(NUM_REGS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (bus.cmd_op)
            OP_READ:  w_state_next = ST_SETTLE;
            OP_DUMP:  w_state_next = ST_SETTLE;
            OP_WRITE: w_state_next = ST_WRITE;
            default:  w_state_next = ST_RESP;
          endcase
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (w_settle_done) begin
          w_state_next = ST_CAPT;
        end else begin
          w_state_next = ST_SETTLE;
        end
      end
      ST_CAPT:  w_state_next = ST_RESP;
      ST_WRITE: w_state_next = ST_RESP;
      ST_RESP: begin
        if (!w_rsp_fire) begin
          w_state_next = ST_RESP;
        end else if (r_dump && !r_rsp_last) begin
          w_state_next = ST_SETTLE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: register-file drive, settle counter and the held response beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_idx        <= '0;
      r_dump       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_addr   <= '0;
      r_rsp_data   <= '0;
      r_rsp_last   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_rd      <= '0;
      r_rf_data    <= '0;
      r_rf_rs1     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (bus.cmd_op)
              OP_READ: begin
                r_rf_rs1     <= bus.cmd_addr;
                r_idx        <= bus.cmd_addr;
                r_settle_cnt <= '0;
              end
              OP_WRITE: begin
                r_rf_we   <= 1'b1;
                r_rf_rd   <= bus.cmd_addr;
                r_rf_data <= bus.cmd_wdata;
              end
              OP_DUMP: begin
                r_rf_rs1     <= '0;
                r_idx        <= '0;
                r_dump       <= 1'b1;
                r_settle_cnt <= '0;
              end
              default: begin
                r_rsp_err   <= 1'b1;
                r_rsp_data  <= '0;
                r_rsp_addr  <= bus.cmd_addr;
                r_rsp_last  <= 1'b1;
                r_rsp_valid <= 1'b1;
              end
            endcase
          end
        end
        ST_SETTLE: begin
          if (!w_settle_done) begin
            r_settle_cnt <= r_settle_cnt + CNT_W'(1);
          end
        end
        ST_CAPT: begin
          r_rsp_data  <= bus.rf_rdata1;
          r_rsp_addr  <= r_idx;
          r_rsp_last  <= !r_dump || w_idx_last;
          r_rsp_valid <= 1'b1;
        end
        ST_WRITE: begin
          // x0 is hardwired, so the echoed value is what the register now really holds
          r_rf_we     <= 1'b0;
          r_rsp_addr  <= r_rf_rd;
          r_rsp_data  <= (r_rf_rd == ADDR_W'(0)) ? XLEN'(0) : r_rf_data;
          r_rsp_last  <= 1'b1;
          r_rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            if (r_dump && !r_rsp_last) begin
              r_idx        <= r_idx + ADDR_W'(1);
              r_rf_rs1     <= r_idx + ADDR_W'(1);
              r_settle_cnt <= '0;
            end else begin
              r_dump    <= 1'b0;
              r_rsp_err <= 1'b0;
            end
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_addr    = r_rsp_addr;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_last    = r_rsp_last;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rf_regWrite = r_rf_we;
  assign bus.rf_rd       = r_rf_rd;
  assign bus.rf_data     = r_rf_data;
  assign bus.rf_rs1      = r_rf_rs1;
  assign bus.dbg_active  = (r_state != ST_IDLE);

endmodule
